// File: rtl/run_trace_if.sv
// Bus bundle for run_trace: run control, chip observation ports and trace-buffer read side.
// master = host/bench side, slave = run_trace.
interface run_trace_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LEN_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             start;
    logic [WIDTH-1:0] entry;
    logic [LEN_W-1:0] run_len;
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] wb;
    logic             rd_en;
    logic             chip_int;
    logic [WIDTH-1:0] chip_entry;
    logic             busy;
    logic             done;
    logic             tr_valid;
    logic [WIDTH-1:0] tr_ins;
    logic [WIDTH-1:0] tr_rd2;
    logic [WIDTH-1:0] tr_wb;
    logic [CW-1:0]    tr_count;
    logic             overflow;

    modport master (
        output start, entry, run_len, ins, rd2, wb, rd_en,
        input  chip_int, chip_entry, busy, done, tr_valid,
        input  tr_ins, tr_rd2, tr_wb, tr_count, overflow
    );

    modport slave (
        input  start, entry, run_len, ins, rd2, wb, rd_en,
        output chip_int, chip_entry, busy, done, tr_valid,
        output tr_ins, tr_rd2, tr_wb, tr_count, overflow
    );
endinterface

// File: rtl/run_trace.sv
// Starts the chip at a latched entry point and records {ins,rd2,wb} for run_len cycles into a FWFT buffer.
// Optional build macro RUN_TRACE_SKIP_NOP_EN: RUN samples with ins==0 are counted but not stored.
module run_trace #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LEN_W = 16
) (
    input logic        clk,
    input logic        INT,
    run_trace_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] ins;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] wb;
    } sample_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remain;
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             ovf;
    logic [WIDTH-1:0] entry_q;
    sample_t          mem [DEPTH];

    logic accept, pop, sample_en, push, drop, full;
    logic chip_int, busy, done;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full   = count[AW];
    assign accept = (state == IDLE || state == DONE) && bus.start && (bus.run_len != '0);
    assign pop    = bus.rd_en && (count != '0) && !accept;

`ifdef RUN_TRACE_SKIP_NOP_EN
    assign sample_en = (state == RUN) && (bus.ins != '0);
`else
    assign sample_en = (state == RUN);
`endif

    // a pop in the same cycle frees the slot a full buffer needs
    assign push = sample_en && (!full || pop);
    assign drop = sample_en && full && !pop;

    always_ff @(posedge clk) begin
        if (INT) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        chip_int  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: begin
                chip_int  = 1'b1;
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (remain == LEN_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            remain  <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            entry_q <= '0;
        end else if (accept) begin
            remain  <= bus.run_len;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            entry_q <= bus.entry;
        end else begin
            if (state == RUN) remain <= remain - 1'b1;
            if (push)         wptr   <= wptr + 1'b1;
            if (pop)          rptr   <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !INT) mem[wptr] <= '{ins: bus.ins, rd2: bus.rd2, wb: bus.wb};
    end

    assign bus.chip_int   = chip_int;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.chip_entry = entry_q;
    assign bus.tr_valid   = (count != '0);
    assign bus.tr_count   = count;
    assign bus.overflow   = ovf;
    assign bus.tr_ins     = mem[rptr].ins;
    assign bus.tr_rd2     = mem[rptr].rd2;
    assign bus.tr_wb      = mem[rptr].wb;
endmodule

// File: tb/tb_run_trace.sv
// Bench for run_trace: directed scenarios plus random runs, checked every cycle against a queue-based model.
module tb_run_trace;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int LEN_W = 16;
`ifdef RUN_TRACE_SKIP_NOP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic INT;
    always #5 clk = ~clk;

    run_trace_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();
    run_trace #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .INT (INT),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] ins;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] wb;
    } smp_t;

    // model: phase 0 idle, 1 loading, 2 running, 3 finished
    smp_t             q[$];
    smp_t             m_first;
    int               m_phase = 0;
    int               m_left  = 0;
    int               m_len   = 0;
    bit               m_ovf   = 1'b0;
    logic [WIDTH-1:0] m_entry = '0;
    int               dut_pops = 0;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randobs();
        bus.ins = ($urandom_range(7) == 0) ? '0 : $urandom;
        bus.rd2 = $urandom;
        bus.wb  = $urandom;
    endtask

    // what one rising edge does, from the rules, using the inputs now applied
    task automatic model_edge();
        bit   acc;
        smp_t s;
        if (bus.rd_en === 1'b1 && bus.tr_valid === 1'b1) dut_pops++;
        if (INT) begin
            m_phase = 0; m_left = 0; m_ovf = 1'b0; m_entry = '0;
            q.delete();
        end else begin
            acc = (m_phase == 0 || m_phase == 3) && bus.start && (bus.run_len != 0);
            if (acc) begin
                q.delete();
                m_ovf = 1'b0; m_entry = bus.entry;
                m_left = int'(bus.run_len); m_len = m_left; m_phase = 1;
            end else begin
                if (bus.rd_en && q.size() > 0) void'(q.pop_front());
                if (m_phase == 1) m_phase = 2;
                else if (m_phase == 2) begin
                    s.ins = bus.ins; s.rd2 = bus.rd2; s.wb = bus.wb;
                    if (m_left == m_len) m_first = s;
                    if (!SKIP || bus.ins != 0) begin
                        if (q.size() < DEPTH) q.push_back(s);
                        else m_ovf = 1'b1;
                    end
                    m_left--;
                    if (m_left == 0) m_phase = 3;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("busy",       bus.busy,       (m_phase == 1 || m_phase == 2));
        chk("done",       bus.done,       (m_phase == 3));
        chk("chip_int",   bus.chip_int,   (m_phase == 1));
        chk("chip_entry", bus.chip_entry, m_entry);
        chk("tr_valid",   bus.tr_valid,   (q.size() > 0));
        chk("tr_count",   bus.tr_count,   q.size());
        chk("overflow",   bus.overflow,   m_ovf);
        if (q.size() > 0) begin
            chk("head_ins", bus.tr_ins, q[0].ins);
            chk("head_rd2", bus.tr_rd2, q[0].rd2);
            chk("head_wb",  bus.tr_wb,  q[0].wb);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // runs from an observed LOAD until done; noise scrambles start/run_len/entry/rd_en meanwhile
    task automatic run_until_done(input int bound, input bit noise, output int runc);
        runc = 0;
        for (int i = 0; i < bound && bus.done !== 1'b1; i++) begin
            randobs();
            if (noise) begin
                bus.start   = 1'($urandom_range(1));
                bus.run_len = LEN_W'($urandom_range(3));
                bus.entry   = $urandom;
                bus.rd_en   = 1'($urandom_range(1));
            end
            tick();
            if (bus.busy === 1'b1 && bus.chip_int === 1'b0) runc++;
        end
        bus.start = 1'b0;
        chk("run_reached_done", bus.done, 1'b1);
    endtask

    task automatic start_run(input logic [WIDTH-1:0] e, input int len);
        bus.entry = e; bus.run_len = LEN_W'(len); bus.start = 1'b1;
        randobs();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        INT = 1'b1;
        tick();
        INT = 1'b0;
    endtask

    initial begin
        int               n, runc;
        logic [WIDTH-1:0] saved;

        INT = 1'b1; bus.start = 1'b0; bus.entry = '0; bus.run_len = '0; bus.rd_en = 1'b0;
        randobs();
        tick();
        INT = 1'b0;
        chk("rst_count", bus.tr_count, 0);
        chk("rst_entry", bus.chip_entry, 0);
        tick();

        // basic run: one LOAD cycle, 43 RUN cycles
        start_run(128, 43);
        chk("load_pulse", bus.chip_int, 1'b1);
        chk("load_entry", bus.chip_entry, 128);
        n = 1;
        for (int i = 0; i < 100 && bus.done !== 1'b1; i++) begin
            randobs(); tick();
            if (bus.busy === 1'b1) n++;
        end
        chk("busy_cycles", n, 44);
        chk("done43", bus.done, 1'b1);
        chk("count43", bus.tr_count, 43);

        // zero-length start is ignored
        do_reset();
        bus.run_len = '0; bus.start = 1'b1;
        tick(); tick();
        bus.start = 1'b0;
        chk("len0_busy", bus.busy, 1'b0);
        chk("len0_chip_int", bus.chip_int, 1'b0);

        // overflow with no reads
        do_reset();
        start_run($urandom, 70);
        run_until_done(200, 1'b0, runc);
        chk("ovf_runc", runc, 70);
        chk("ovf_count", bus.tr_count, DEPTH);
        chk("ovf_flag", bus.overflow, 1'b1);
        chk("ovf_head", bus.tr_ins, m_first.ins);

        // continuous reads keep up, nothing dropped
        do_reset();
        start_run($urandom, 70);
        bus.rd_en = 1'b1; dut_pops = 0;
        run_until_done(200, 1'b0, runc);
        randobs(); tick();
        bus.rd_en = 1'b0;
        chk("drain_pops", dut_pops, 70);
        chk("drain_count", bus.tr_count, 0);
        chk("drain_ovf", bus.overflow, 1'b0);

        // abort at RUN cycle 10, then a clean run with start noise during RUN
        do_reset();
        start_run($urandom, 43);
        for (int i = 0; i < 10; i++) begin randobs(); tick(); end
        INT = 1'b1; bus.start = 1'b1; bus.rd_en = 1'b1;
        tick();
        INT = 1'b0; bus.start = 1'b0; bus.rd_en = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_count", bus.tr_count, 0);
        saved = $urandom;
        start_run(saved, 20);
        run_until_done(100, 1'b1, runc);
        bus.rd_en = 1'b0;
        chk("noise_runc", runc, 20);
        chk("noise_entry", bus.chip_entry, saved);

        // random runs, pops and occasional aborts
        for (int r = 0; r < 8; r++) begin
            start_run($urandom, $urandom_range(90, 1));
            for (int i = 0; i < 120 && bus.done !== 1'b1; i++) begin
                randobs();
                bus.rd_en = 1'($urandom_range(3) == 0);
                bus.start = 1'($urandom_range(1));
                INT = 1'($urandom_range(199) == 0);
                tick();
                INT = 1'b0;
                if (bus.busy !== 1'b1) break;
            end
            bus.start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                bus.rd_en = 1'($urandom_range(1));
                randobs(); tick();
            end
            bus.rd_en = 1'b0;
        end

        // NOP samples on RUN cycles 3 and 7
        do_reset();
        start_run($urandom, 10);
        randobs(); tick();
        for (int i = 1; i <= 10; i++) begin
            randobs();
            bus.ins = (i == 3 || i == 7) ? '0 : WIDTH'(i * 16 + 1);
            tick();
        end
        chk("nop_done", bus.done, 1'b1);
        chk("nop_count", bus.tr_count, SKIP ? 8 : 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
